// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and instruction memory (slave); the response may come back in the request cycle or several cycles later.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        valid;

  modport master (output req, output addr, input rdata, input valid);
  modport slave  (input req, input addr, output rdata, output valid);
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: holds the PC, selects the next PC from ID operands,
// and handshakes with instruction memory, buffering the word while IF/ID is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_3FFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_en,
  input  logic [1:0]        i_npc_sel,
  input  logic              i_branch_taken,
  input  logic [31:0]       i_pc4_d,
  input  logic [25:0]       i_imm26_d,
  input  logic [31:0]       i_rs_val_d,
  fetch_stage_if.master     imem,
  output logic [31:0]       o_pc_f,
  output logic [31:0]       o_pc4_f,
  output logic [31:0]       o_instr_f,
  output logic              o_valid_f,
  output logic              o_exc_adel_f
);

  typedef enum logic {S_FETCH, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_buf_nxt;
  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_next_pc;
  logic [31:0] w_instr;
  logic        w_addr_bad;
  logic        w_req;
  logic        w_valid;

  assign w_addr_bad = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_LIMIT);
  assign w_pc4      = r_pc + 32'd4;
  assign w_br_off   = {{14{i_imm26_d[15]}}, i_imm26_d[15:0], 2'b00};

  // jr targets pass through unchecked; a misaligned one shows up as exc_adel_f once it becomes pc_f.
  always_comb begin
    w_next_pc = w_pc4;
    case (i_npc_sel)
      2'b01:   w_next_pc = i_branch_taken ? (i_pc4_d + w_br_off) : w_pc4;
      2'b10:   w_next_pc = {i_pc4_d[31:28], i_imm26_d, 2'b00};
      2'b11:   w_next_pc = i_rs_val_d;
      default: w_next_pc = w_pc4;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_buf_nxt   = r_buf;
    w_req       = 1'b0;
    w_instr     = 32'h0000_0000;
    w_valid     = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (w_addr_bad) begin
          w_valid = 1'b1;
        end else begin
          w_req   = 1'b1;
          w_instr = imem.rdata;
          w_valid = imem.valid;
        end
      end
      S_HOLD: begin
        w_instr = r_buf;
        w_valid = 1'b1;
      end
      default: begin
        w_valid = 1'b0;
      end
    endcase

    if (w_valid && i_en) begin
      w_pc_nxt    = w_next_pc;
      w_state_nxt = S_FETCH;
    end else if (w_valid && (r_state == S_FETCH)) begin
      w_buf_nxt   = w_instr;
      w_state_nxt = S_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_buf   <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  // Masking with reset_n keeps a response landing in the reset cycle from looking like a fetch.
  assign imem.req     = w_req & reset_n;
  assign imem.addr    = r_pc;
  assign o_pc_f       = r_pc;
  assign o_pc4_f      = w_pc4;
  assign o_instr_f    = w_instr;
  assign o_valid_f    = w_valid & reset_n;
  assign o_exc_adel_f = w_addr_bad;

endmodule
